// File: rtl/mlu_wb_pkg.sv
// Shared types and sizing constants for the MLU writeback queue.
// The result entry width follows WB_TAG_W / WB_DATA_W; top-level widths default to these.
package mlu_wb_pkg;

  localparam int WB_DATA_W     = 64;
  localparam int WB_TAG_W      = 5;
  localparam int DEFAULT_DEPTH = 4;
  localparam int CNT_W         = $clog2(DEFAULT_DEPTH) + 1;

  typedef struct packed {
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mlu_wb_fifo.sv
// Synchronous FIFO with async active-low reset and a synchronous clear that overrides push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module mlu_wb_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  // Storage write; slots outside the valid window are don't-care.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == '0);
  assign full  = (count_r == (PTR_W+1)'(DEPTH));
  assign count = count_r;

endmodule

// File: rtl/mlu_writeback_queue.sv
// Pairs MLU results with issue-time rd tags and hands them to writeback in order, with credit throttling.
// Optional same-cycle bypass to writeback when the result FIFO is empty: define MLU_WB_BYPASS_EN.
module mlu_writeback_queue
  import mlu_wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int TAG_WIDTH  = WB_TAG_W,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [TAG_WIDTH-1:0]   issue_tag,
  output logic                   issue_ready,
  input  logic                   flush,
  input  logic                   mlu_valid_result,
  input  logic [DATA_WIDTH-1:0]  mlu_result,
  output logic                   mlu_ready_i,
  output logic                   wb_valid,
  output logic [TAG_WIDTH-1:0]   wb_tag,
  output logic [DATA_WIDTH-1:0]  wb_data,
  input  logic                   wb_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   orphan_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                 issue_accept_s;
  logic                 res_accept_s;
  logic                 tag_pop_s;
  logic                 drop_dec_s;
  logic                 orphan_hit_s;
  logic                 bypass_s;
  logic                 res_push_s;
  logic                 res_pop_s;
  logic [TAG_WIDTH-1:0] tag_head_s;
  logic                 tag_empty_s;
  logic                 tag_full_s;
  logic [OCC_W-1:0]     tag_count_s;
  wb_entry_t            res_entry_s;
  wb_entry_t            res_head_s;
  logic                 res_empty_s;
  logic                 res_full_s;
  logic [OCC_W-1:0]     res_count_s;
  logic [OCC_W-1:0]     drop_cnt_r;
  logic                 orphan_err_r;

  assign occupancy      = tag_count_s + res_count_s + drop_cnt_r;
  assign issue_ready    = (occupancy < OCC_W'(DEPTH));
  assign mlu_ready_i    = !res_full_s;
  assign issue_accept_s = issue_valid && issue_ready && !flush && !tag_full_s;
  assign res_accept_s   = mlu_valid_result && mlu_ready_i;
  assign res_entry_s    = '{tag: tag_head_s, data: mlu_result};

  // Results owed to flushed ops are consumed first; results with nothing owed are orphans.
  always_comb begin
    tag_pop_s    = 1'b0;
    drop_dec_s   = 1'b0;
    orphan_hit_s = 1'b0;
    if (!res_accept_s) begin
      tag_pop_s = 1'b0;
    end else if (drop_cnt_r != '0) begin
      drop_dec_s = 1'b0 | 1'b1;
    end else if (tag_empty_s) begin
      orphan_hit_s = 1'b1;
    end else begin
      tag_pop_s = 1'b1;
    end
  end

`ifdef MLU_WB_BYPASS_EN
  assign bypass_s = tag_pop_s && !flush && res_empty_s && wb_ready;
`else
  assign bypass_s = 1'b0;
`endif

  assign res_push_s = tag_pop_s && !flush && !bypass_s;
  assign res_pop_s  = !res_empty_s && wb_ready;

  // Writeback port: bypassed result wins, otherwise the buffered head; zero when idle.
  always_comb begin
    wb_valid = 1'b0;
    wb_tag   = '0;
    wb_data  = '0;
    if (bypass_s) begin
      wb_valid = 1'b1;
      wb_tag   = tag_head_s;
      wb_data  = mlu_result;
    end else if (!res_empty_s) begin
      wb_valid = 1'b1;
      wb_tag   = res_head_s.tag;
      wb_data  = res_head_s.data;
    end else begin
      wb_valid = 1'b0;
    end
  end

  // On flush every still-pending tag becomes a result to discard, less one consumed this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= '0;
    end else if (flush) begin
      drop_cnt_r <= drop_cnt_r - OCC_W'(drop_dec_s) + tag_count_s - OCC_W'(tag_pop_s);
    end else begin
      drop_cnt_r <= drop_cnt_r - OCC_W'(drop_dec_s);
    end
  end

  // Sticky orphan flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      orphan_err_r <= 1'b0;
    end else if (orphan_hit_s) begin
      orphan_err_r <= 1'b1;
    end
  end

  assign orphan_err = orphan_err_r;

  mlu_wb_fifo #(
    .T     (logic [TAG_WIDTH-1:0]),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (issue_accept_s),
    .push_data (issue_tag),
    .pop       (tag_pop_s),
    .head      (tag_head_s),
    .empty     (tag_empty_s),
    .full      (tag_full_s),
    .count     (tag_count_s)
  );

  mlu_wb_fifo #(
    .T     (wb_entry_t),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (res_push_s),
    .push_data (res_entry_s),
    .pop       (res_pop_s),
    .head      (res_head_s),
    .empty     (res_empty_s),
    .full      (res_full_s),
    .count     (res_count_s)
  );

endmodule
